// File: rtl/combi_seq_pkg.sv
// Shared types and encoding helpers for the ARM LDM/STM micro-op sequencer.
// Optional feature macro: ARM_MULTI_WRITEBACK_EN (adds the base-writeback micro-op and WB state).
package combi_seq_pkg;

`ifdef ARM_MULTI_WRITEBACK_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        PCLD = 2'd3
    } seq_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        PCLD = 2'd3
    } seq_state_t;
`endif

    // MOV R0,R0 -- stands in for an LDM/STM with an empty register list
    localparam logic [31:0] SEQ_NOP_INSTR  = 32'hE1A00000;
    localparam int          SEQ_WORD_BYTES = 4;

    // Bits [27:25] instruction classes
    localparam logic [2:0]  MULTI_CLASS    = 3'b100;
    localparam logic [2:0]  LDST_IMM_CLASS = 3'b010;
    localparam logic [2:0]  DP_IMM_CLASS   = 3'b001;

    // Data-processing opcodes used for the writeback micro-op
    localparam logic [3:0]  OP_ADD = 4'b0100;
    localparam logic [3:0]  OP_SUB = 4'b0010;

    localparam logic [15:0] R15_BIT = 16'h8000;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'b0000, v[i]};
        return c;
    endfunction

    // Pre-indexed, no-writeback LDR/STR immediate; U bit follows the offset sign
    function automatic logic [31:0] enc_xfer(input logic [3:0] cond, input logic l,
                                             input logic [3:0] rn, input logic [3:0] rd,
                                             input logic signed [7:0] off);
        logic [7:0] mag;
        mag = off[7] ? 8'(-off) : 8'(off);
        return {cond, LDST_IMM_CLASS, 1'b1, ~off[7], 1'b0, 1'b0, l, rn, rd, 4'b0000, mag};
    endfunction

    // ADD/SUB Rn,Rn,#nbytes for the base update
    function automatic logic [31:0] enc_wb(input logic [3:0] cond, input logic u,
                                           input logic [3:0] rn, input logic [7:0] nbytes);
        return {cond, DP_IMM_CLASS, (u ? OP_ADD : OP_SUB), 1'b0, rn, rn, 4'b0000, nbytes};
    endfunction

endpackage

// File: rtl/arm_reglist_pick.sv
// Picks the lowest eligible register of a pending LDM/STM register mask and
// reports its rank within the original register list.
module arm_reglist_pick
    import combi_seq_pkg::*;
(
    input  logic [15:0] pend,
    input  logic [15:0] excl,
    input  logic [15:0] list,
    output logic [3:0]  pick_reg,
    output logic [4:0]  pick_rank,
    output logic        cand_empty
);

    logic [15:0] cand;

    assign cand = pend & ~excl;

    // Priority scan from R15 down so the lowest set bit wins
    always_comb begin
        pick_reg   = '0;
        cand_empty = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            if (cand[i]) begin
                pick_reg   = 4'(i);
                cand_empty = 1'b0;
            end
        end
    end

    // Rank counts listed registers numbered below the pick
    always_comb begin
        pick_rank = popcount16(list & ((16'h1 << pick_reg) - 16'h1));
    end

endmodule

// File: rtl/arm_multi_seq.sv
// Decode-stage sequencer expanding ARM LDM/STM into single-register LDR/STR
// micro-ops; everything else passes through untouched.
// Optional feature macro: ARM_MULTI_WRITEBACK_EN (base-writeback ADD/SUB micro-op).
module arm_multi_seq
    import combi_seq_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR  = SEQ_NOP_INSTR,
    parameter int          WORD_BYTES = SEQ_WORD_BYTES
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic        armD,
    input  logic        validD,
    input  logic        StallD,
    input  logic        FlushD,
    output logic [31:0] InstrSeqD,
    output logic        SeqStallF,
    output logic        SeqBusy
);

    localparam logic signed [7:0] STRIDE = 8'(WORD_BYTES);

    seq_state_t  state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic [31:0] instr_q, instr_d;

    logic [31:0] act;
    logic        multi;
    logic [3:0]  cond, rn;
    logic        p, u, l;
    logic [15:0] list, pend_cur, rn_bit, others, excl;
    logic [4:0]  n;
    logic [7:0]  nbytes;
    logic [3:0]  pick_reg;
    logic [4:0]  pick_rank;
    logic        cand_empty;
    logic        unused_fields;

    // Signed byte offset of a register's slot relative to the base register
    function automatic logic signed [7:0] xfer_offset(input logic pb, input logic ub,
                                                      input logic [4:0] cnt,
                                                      input logic [4:0] rank);
        logic signed [7:0] cnt_s, rank_s, base;
        cnt_s  = signed'({3'b000, cnt});
        rank_s = signed'({3'b000, rank});
        case ({pb, ub})
            2'b01:   base = 8'sd0;
            2'b11:   base = STRIDE;
            2'b00:   base = STRIDE - STRIDE * cnt_s;
            default: base = -(STRIDE * cnt_s);
        endcase
        return base + STRIDE * rank_s;
    endfunction

    // While sequencing, all fields come from the latched instruction
    assign act      = (state_q == IDLE) ? InstrD : instr_q;
    assign multi    = armD & validD & (InstrD[27:25] == MULTI_CLASS);
    assign cond     = act[31:28];
    assign p        = act[24];
    assign u        = act[23];
    assign l        = act[20];
    assign rn       = act[19:16];
    assign list     = act[15:0];
    assign n        = popcount16(list);
    assign nbytes   = 8'({3'b000, n} * 8'(WORD_BYTES));
    assign rn_bit   = 16'h1 << rn;
    assign pend_cur = (state_q == IDLE) ? list : pend_q;

    // LDM defers Rn and R15; Rn becomes eligible once only it (and R15) remain
    assign others = pend_cur & ~rn_bit & ~R15_BIT;
    assign excl   = l ? ((|others) ? (rn_bit | R15_BIT) : R15_BIT) : 16'h0000;

    // S bit and class bits do not affect the expansion
    assign unused_fields = ^act[27:21];

`ifdef ARM_MULTI_WRITEBACK_EN
    logic wb_en;
    assign wb_en = act[21] & ~(l & list[rn]);
`endif

    arm_reglist_pick u_pick (
        .pend       (pend_cur),
        .excl       (excl),
        .list       (list),
        .pick_reg   (pick_reg),
        .pick_rank  (pick_rank),
        .cand_empty (cand_empty)
    );

    assign SeqBusy = (state_q != IDLE);

    // Choose the current micro-op, its successor state and the updated pending mask
    always_comb begin
        logic        do_seq, emit, use_wb;
        logic [3:0]  xfer_rd;
        logic [4:0]  xfer_rank;
        logic [15:0] pend_nxt, rem;
        seq_state_t  nxt;

        InstrSeqD = InstrD;
        SeqStallF = 1'b0;
        state_d   = state_q;
        pend_d    = pend_q;
        instr_d   = instr_q;
        do_seq    = 1'b0;
        emit      = 1'b0;
        use_wb    = 1'b0;
        xfer_rd   = pick_reg;
        xfer_rank = pick_rank;
        pend_nxt  = pend_cur;
        rem       = '0;
        nxt       = IDLE;

        case (state_q)
            IDLE: begin
                if (multi) begin
                    if (n == 5'd0) InstrSeqD = NOP_INSTR;
                    else           do_seq = 1'b1;
                end
            end
            XFER: do_seq = 1'b1;
`ifdef ARM_MULTI_WRITEBACK_EN
            WB: begin
                emit   = 1'b1;
                use_wb = 1'b1;
                nxt    = (l && pend_q[15]) ? PCLD : IDLE;
            end
`endif
            PCLD: begin
                emit      = 1'b1;
                xfer_rd   = 4'd15;
                xfer_rank = n - 5'd1;
                pend_nxt  = '0;
                nxt       = IDLE;
            end
            default: ;
        endcase

        if (do_seq) begin
            emit = 1'b1;
            if (!cand_empty) begin
                pend_nxt = pend_cur & ~(16'h1 << pick_reg);
                rem      = l ? (pend_nxt & ~R15_BIT) : pend_nxt;
                if (|rem) nxt = XFER;
`ifdef ARM_MULTI_WRITEBACK_EN
                else if (wb_en) nxt = WB;
`endif
                else if (l && pend_nxt[15]) nxt = PCLD;
                else nxt = IDLE;
            end
`ifdef ARM_MULTI_WRITEBACK_EN
            else if (wb_en) begin
                use_wb = 1'b1;
                nxt    = (l && pend_cur[15]) ? PCLD : IDLE;
            end
`endif
            else begin
                // Only R15 is left: it goes out as the final load
                xfer_rd   = 4'd15;
                xfer_rank = n - 5'd1;
                pend_nxt  = '0;
                nxt       = IDLE;
            end
        end

        if (emit) begin
            InstrSeqD = use_wb ? enc_wb(cond, u, rn, nbytes)
                               : enc_xfer(cond, l, rn, xfer_rd, xfer_offset(p, u, n, xfer_rank));
            SeqStallF = (nxt != IDLE);
            if (!StallD) begin
                state_d = nxt;
                pend_d  = pend_nxt;
                if (state_q == IDLE) instr_d = InstrD;
            end
        end

        if (FlushD) begin
            state_d = IDLE;
            pend_d  = '0;
        end

        // Reset forces passthrough immediately, without waiting for the register update
        if (reset) begin
            InstrSeqD = InstrD;
            SeqStallF = 1'b0;
        end
    end

    // Sequencer state, pending mask and latched instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: tb/tb_arm_multi_seq.sv
// Self-checking bench for arm_multi_seq: directed vector table, hand-written
// stall/flush/reset sequences, and random instructions against a reference model.
module tb_arm_multi_seq;

    logic        clk;
    logic        reset;
    logic [31:0] InstrD;
    logic        armD;
    logic        validD;
    logic        StallD;
    logic        FlushD;
    logic [31:0] InstrSeqD;
    logic        SeqStallF;
    logic        SeqBusy;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        string             name;
        logic [31:0]       instr;
        logic              arm;
        int                nops;
        logic [3:0][31:0]  ops;
    } vec_t;

    vec_t tbl[$];

    arm_multi_seq dut (
        .clk       (clk),
        .reset     (reset),
        .InstrD    (InstrD),
        .armD      (armD),
        .validD    (validD),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .InstrSeqD (InstrSeqD),
        .SeqStallF (SeqStallF),
        .SeqBusy   (SeqBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
    endtask

    task automatic add_vec(input string nm, input logic [31:0] ins, input logic arm, input int n,
                           input logic [31:0] o0, input logic [31:0] o1,
                           input logic [31:0] o2, input logic [31:0] o3);
        vec_t v;
        v.name  = nm;
        v.instr = ins;
        v.arm   = arm;
        v.nops  = n;
        v.ops[0] = o0;
        v.ops[1] = o1;
        v.ops[2] = o2;
        v.ops[3] = o3;
        tbl.push_back(v);
    endtask

    // Reference: LDR/STR immediate word for register r of the block transfer ins
    function automatic logic [31:0] model_xfer(input logic [31:0] ins, input int r);
        int cnt  = 0;
        int rank = 0;
        int base;
        int off;
        logic [11:0] imm;
        for (int i = 0; i < 16; i++) begin
            if (ins[i]) begin
                cnt++;
                if (i < r) rank++;
            end
        end
        case ({ins[24], ins[23]})
            2'b01:   base = 0;
            2'b11:   base = 4;
            2'b00:   base = 4 - 4 * cnt;
            default: base = -4 * cnt;
        endcase
        off = base + 4 * rank;
        imm = 12'(off < 0 ? -off : off);
        return {ins[31:28], 3'b010, 1'b1, (off >= 0), 2'b00, ins[20], ins[19:16], 4'(r), imm};
    endfunction

    function automatic logic [31:0] model_wb(input logic [31:0] ins);
        int cnt = 0;
        for (int i = 0; i < 16; i++) if (ins[i]) cnt++;
        return {ins[31:28], 3'b001, (ins[23] ? 4'b0100 : 4'b0010), 1'b0,
                ins[19:16], ins[19:16], 4'b0000, 8'(4 * cnt)};
    endfunction

    // Reference: full ordered micro-op list for one decode-slot instruction
    task automatic model_ops(input logic [31:0] ins, input logic arm, input logic valid);
        int  rn;
        bit  wb;
        exp_q.delete();
        rn = int'(ins[19:16]);
        if (!(arm && valid && ins[27:25] == 3'b100)) begin
            exp_q.push_back(ins);
            return;
        end
        if (ins[15:0] == 16'h0000) begin
            exp_q.push_back(32'hE1A00000);
            return;
        end
`ifdef ARM_MULTI_WRITEBACK_EN
        wb = ins[21] && !(ins[20] && ins[rn]);
`else
        wb = 1'b0;
`endif
        if (!ins[20]) begin
            for (int r = 0; r < 16; r++) if (ins[r]) exp_q.push_back(model_xfer(ins, r));
            if (wb) exp_q.push_back(model_wb(ins));
        end else begin
            for (int r = 0; r < 15; r++)
                if (ins[r] && r != rn) exp_q.push_back(model_xfer(ins, r));
            if (ins[rn] && rn != 15) exp_q.push_back(model_xfer(ins, rn));
            if (wb) exp_q.push_back(model_wb(ins));
            if (ins[15]) exp_q.push_back(model_xfer(ins, 15));
        end
    endtask

    // Walk exp_q cycle by cycle with inputs already driven; optional random decode stalls
    task automatic run_expect(input string nm, input bit use_stall);
        int k = 0;
        int guard = 0;
        int n = exp_q.size();
        while (k < n && guard < 200) begin
            StallD = use_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            chk({nm, "_instr"}, InstrSeqD, exp_q[k]);
            chk({nm, "_stallf"}, {31'b0, SeqStallF}, {31'b0, (k < n - 1)});
            chk({nm, "_busy"}, {31'b0, SeqBusy}, {31'b0, (k > 0)});
            @(posedge clk);
            #1;
            if (!StallD) k++;
            guard++;
        end
        StallD = 1'b0;
        n_total++;
        if (k >= n) n_pass++;
        else $display("FAIL %s_timeout: got %0d ops, expected %0d", nm, k, n);
    endtask

    function automatic logic [31:0] rand_multi();
        logic [15:0] lst;
        case ($urandom_range(0, 3))
            0:       lst = 16'h0000;
            1:       lst = 16'h1 << $urandom_range(0, 15);
            2:       lst = 16'($urandom) & 16'($urandom);
            default: lst = 16'($urandom);
        endcase
        return {4'($urandom), 3'b100, 5'($urandom), 4'($urandom), lst};
    endfunction

    initial begin
        logic [31:0] ins;
        logic        arm, valid;

        // ---------------- reset state ----------------
        reset  = 1'b1;
        InstrD = 32'hE2811001;
        armD   = 1'b1;
        validD = 1'b1;
        StallD = 1'b0;
        FlushD = 1'b0;
        #2;
        chk("rst_busy", {31'b0, SeqBusy}, 32'd0);
        chk("rst_stallf", {31'b0, SeqStallF}, 32'd0);
        chk("rst_pass", InstrSeqD, 32'hE2811001);
        InstrD = 32'hE8AD0007;
        #1;
        chk("rst_multi_pass", InstrSeqD, 32'hE8AD0007);
        chk("rst_multi_stallf", {31'b0, SeqStallF}, 32'd0);
        InstrD = 32'hE2811001;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- directed vector table ----------------
`ifdef ARM_MULTI_WRITEBACK_EN
        add_vec("stmia_wb", 32'hE8AD0007, 1'b1, 4, 32'hE58D0000, 32'hE58D1004, 32'hE58D2008, 32'hE28DD00C);
        add_vec("ldmia_pc_wb", 32'hE8B48002, 1'b1, 3, 32'hE5941000, 32'hE2844008, 32'hE594F004, 32'h0);
`else
        add_vec("stmia", 32'hE8AD0007, 1'b1, 3, 32'hE58D0000, 32'hE58D1004, 32'hE58D2008, 32'h0);
        add_vec("ldmia_pc", 32'hE8B48002, 1'b1, 2, 32'hE5941000, 32'hE594F004, 32'h0, 32'h0);
`endif
        add_vec("ldmdb", 32'hE9100006, 1'b1, 2, 32'hE5101008, 32'hE5102004, 32'h0, 32'h0);
        add_vec("ldmia_rn", 32'hE8B1000A, 1'b1, 2, 32'hE5913004, 32'hE5911000, 32'h0, 32'h0);
        add_vec("stmib", 32'hE9820009, 1'b1, 2, 32'hE5820004, 32'hE5823008, 32'h0, 32'h0);
        add_vec("ldmda", 32'hE8150284, 1'b1, 3, 32'hE5152008, 32'hE5157004, 32'hE5959000, 32'h0);
        add_vec("empty", 32'hE8900000, 1'b1, 1, 32'hE1A00000, 32'h0, 32'h0, 32'h0);
        add_vec("riscv", 32'h08B10093, 1'b0, 1, 32'h08B10093, 32'h0, 32'h0, 32'h0);
        add_vec("arm_add", 32'hE2811001, 1'b1, 1, 32'hE2811001, 32'h0, 32'h0, 32'h0);

        foreach (tbl[t]) begin
            InstrD = tbl[t].instr;
            armD   = tbl[t].arm;
            validD = 1'b1;
            exp_q.delete();
            for (int k = 0; k < tbl[t].nops; k++) exp_q.push_back(tbl[t].ops[k]);
            run_expect(tbl[t].name, 1'b0);
        end

        // ---------------- StallD held on the second micro-op ----------------
        InstrD = 32'hE8AD0007;
        armD   = 1'b1;
        validD = 1'b1;
        @(negedge clk);
        chk("stall_op0", InstrSeqD, 32'hE58D0000);
        @(posedge clk);
        #1;
        StallD = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_hold", InstrSeqD, 32'hE58D1004);
            chk("stall_hold_stallf", {31'b0, SeqStallF}, 32'd1);
            @(posedge clk);
            #1;
            if (c == 1) StallD = 1'b0;
        end
        @(negedge clk);
        chk("stall_op2", InstrSeqD, 32'hE58D2008);
`ifdef ARM_MULTI_WRITEBACK_EN
        chk("stall_op2_stallf", {31'b0, SeqStallF}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_op3", InstrSeqD, 32'hE28DD00C);
`endif
        chk("stall_last_stallf", {31'b0, SeqStallF}, 32'd0);
        @(posedge clk);
        #1;

        // ---------------- FlushD mid-sequence ----------------
        InstrD = 32'hE8AD0007;
        @(negedge clk);
        chk("flush_op0", InstrSeqD, 32'hE58D0000);
        @(posedge clk);
        #1;
        FlushD = 1'b1;
        @(negedge clk);
        chk("flush_op1", InstrSeqD, 32'hE58D1004);
        @(posedge clk);
        #1;
        FlushD = 1'b0;
        InstrD = 32'hE2811001;
        @(negedge clk);
        chk("flush_pass", InstrSeqD, 32'hE2811001);
        chk("flush_stallf", {31'b0, SeqStallF}, 32'd0);
        chk("flush_busy", {31'b0, SeqBusy}, 32'd0);
        @(posedge clk);
        #1;

        // ---------------- asynchronous reset in XFER ----------------
        InstrD = 32'hE8AD0007;
        @(negedge clk);
        chk("areset_op0", InstrSeqD, 32'hE58D0000);
        @(posedge clk);
        #3;
        chk("areset_busy_before", {31'b0, SeqBusy}, 32'd1);
        chk("areset_stallf_before", {31'b0, SeqStallF}, 32'd1);
        reset = 1'b1;
        #1;
        chk("areset_busy", {31'b0, SeqBusy}, 32'd0);
        chk("areset_stallf", {31'b0, SeqStallF}, 32'd0);
        chk("areset_pass", InstrSeqD, 32'hE8AD0007);
        InstrD = 32'hE2811001;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("areset_after_busy", {31'b0, SeqBusy}, 32'd0);
        chk("areset_after_pass", InstrSeqD, 32'hE2811001);
        @(posedge clk);
        #1;

        // ---------------- random instructions vs reference model ----------------
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                ins   = rand_multi();
                arm   = ($urandom_range(0, 7) != 0);
                valid = ($urandom_range(0, 7) != 0);
            end else begin
                ins   = $urandom;
                arm   = 1'($urandom);
                valid = 1'($urandom);
            end
            InstrD = ins;
            armD   = arm;
            validD = valid;
            model_ops(ins, arm, valid);
            run_expect("rand", 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
